// File: rtl/rename_stage.sv
// Register rename stage: speculative RAT plus a circular free list.
// Renamed instructions leave through a single registered valid/ready slot.
module rename_stage #(
    parameter int MAX_OPERANDS = 3,
    parameter int NUM_PRN      = 64,
    parameter int PRN_W        = $clog2(NUM_PRN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2:0]              in_fu_choice,
    input  logic [5:0]              in_lrn_src [MAX_OPERANDS],
    input  logic [MAX_OPERANDS-1:0] in_src_mask,
    input  logic [5:0]              in_lrn_dst [MAX_OPERANDS],
    input  logic [MAX_OPERANDS-1:0] in_dst_mask,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2:0]              out_fu_choice,
    output logic [PRN_W-1:0]        out_prn_src [MAX_OPERANDS],
    output logic [PRN_W-1:0]        out_prn_dst [MAX_OPERANDS],
    output logic [PRN_W-1:0]        out_prn_old [MAX_OPERANDS],
    output logic [MAX_OPERANDS-1:0] out_dst_mask,
    input  logic [MAX_OPERANDS-1:0] free_valid,
    input  logic [PRN_W-1:0]        free_prn [MAX_OPERANDS]
);
    localparam int               NUM_LRN    = 64;
    localparam int               ARCH_REGS  = 33;
    localparam int               FIRST_FREE = ARCH_REGS + 1;
    localparam int               CNT_W      = PRN_W + 1;
    localparam logic [5:0]       ZERO_LRN   = 6'd63;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(NUM_PRN);

    logic [PRN_W-1:0] rat_reg [NUM_LRN];
    logic [PRN_W-1:0] fl_reg  [NUM_PRN];
    logic [PRN_W-1:0] head_reg;
    logic [PRN_W-1:0] tail_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    logic                    out_valid_reg;
    logic [2:0]              out_fu_choice_reg;
    logic [PRN_W-1:0]        out_prn_src_reg [MAX_OPERANDS];
    logic [PRN_W-1:0]        out_prn_dst_reg [MAX_OPERANDS];
    logic [PRN_W-1:0]        out_prn_old_reg [MAX_OPERANDS];
    logic [MAX_OPERANDS-1:0] out_dst_mask_reg;

    logic [MAX_OPERANDS-1:0] alloc;
    logic [MAX_OPERANDS-1:0] push_ok;
    logic [MAX_OPERANDS-1:0] drop;
    logic [PRN_W-1:0]        alloc_off [MAX_OPERANDS];
    logic [PRN_W-1:0]        push_off  [MAX_OPERANDS];
    logic [PRN_W-1:0]        src_prn   [MAX_OPERANDS];
    logic [PRN_W-1:0]        new_prn   [MAX_OPERANDS];
    logic [PRN_W-1:0]        old_prn   [MAX_OPERANDS];
    logic [CNT_W-1:0]        need;
    logic [CNT_W-1:0]        push_cnt;
    logic                    fire;

    // Lookups use the RAT as it stood before this instruction's own writes.
    generate
        for (genvar gi = 0; gi < MAX_OPERANDS; gi++) begin : g_slot
            assign src_prn[gi] = (in_src_mask[gi] && in_lrn_src[gi] != ZERO_LRN)
                                 ? rat_reg[in_lrn_src[gi]] : '0;
            assign alloc[gi]   = in_dst_mask[gi] && (in_lrn_dst[gi] != ZERO_LRN);
            assign new_prn[gi] = alloc[gi] ? fl_reg[head_reg + alloc_off[gi]] : '0;
            assign old_prn[gi] = alloc[gi] ? rat_reg[in_lrn_dst[gi]] : '0;
        end
    endgenerate

    // Prefix counts give each allocating slot its pop offset and each release its push offset.
    always_comb begin
        need     = '0;
        push_cnt = '0;
        push_ok  = '0;
        drop     = '0;
        for (int s = 0; s < MAX_OPERANDS; s++) begin
            alloc_off[s] = need[PRN_W-1:0];
            push_off[s]  = push_cnt[PRN_W-1:0];
            if (alloc[s]) begin
                need = need + CNT_ONE;
            end
            if (free_valid[s] && free_prn[s] != '0) begin
                if (count_reg + push_cnt < FULL_CNT) begin
                    push_ok[s] = 1'b1;
                    push_cnt   = push_cnt + CNT_ONE;
                end else begin
                    drop[s] = 1'b1;
                end
            end
        end
    end

    assign in_ready   = (!out_valid_reg || out_ready) && (count_reg >= need);
    assign fire       = in_valid && in_ready;
    assign count_next = count_reg + push_cnt - (fire ? need : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LRN; i++) begin
                rat_reg[i] <= (i < ARCH_REGS) ? PRN_W'(i + 1) : '0;
            end
            for (int i = 0; i < NUM_PRN; i++) begin
                fl_reg[i] <= PRN_W'(i);
            end
            head_reg  <= PRN_W'(FIRST_FREE);
            tail_reg  <= PRN_W'(NUM_PRN);
            count_reg <= CNT_W'(NUM_PRN - FIRST_FREE);
        end else begin
            // Later slots overwrite earlier ones, so duplicates keep the highest slot's PRN.
            if (fire) begin
                for (int s = 0; s < MAX_OPERANDS; s++) begin
                    if (alloc[s]) begin
                        rat_reg[in_lrn_dst[s]] <= new_prn[s];
                    end
                end
                head_reg <= head_reg + need[PRN_W-1:0];
            end
            for (int s = 0; s < MAX_OPERANDS; s++) begin
                if (push_ok[s]) begin
                    fl_reg[tail_reg + push_off[s]] <= free_prn[s];
                end
            end
            tail_reg  <= tail_reg + push_cnt[PRN_W-1:0];
            count_reg <= count_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg     <= 1'b0;
            out_fu_choice_reg <= '0;
            out_dst_mask_reg  <= '0;
            for (int s = 0; s < MAX_OPERANDS; s++) begin
                out_prn_src_reg[s] <= '0;
                out_prn_dst_reg[s] <= '0;
                out_prn_old_reg[s] <= '0;
            end
        end else if (fire) begin
            out_valid_reg     <= 1'b1;
            out_fu_choice_reg <= in_fu_choice;
            out_dst_mask_reg  <= alloc;
            for (int s = 0; s < MAX_OPERANDS; s++) begin
                out_prn_src_reg[s] <= src_prn[s];
                out_prn_dst_reg[s] <= new_prn[s];
                out_prn_old_reg[s] <= old_prn[s];
            end
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (drop == '0) else $error("rename_stage: release dropped, free list already full");
        end
    end

    assign out_valid     = out_valid_reg;
    assign out_fu_choice = out_fu_choice_reg;
    assign out_dst_mask  = out_dst_mask_reg;
    assign out_prn_src   = out_prn_src_reg;
    assign out_prn_dst   = out_prn_dst_reg;
    assign out_prn_old   = out_prn_old_reg;

endmodule

// File: tb/tb_rename_stage.sv
// Directed and randomized checks for rename_stage: mapping, allocation order,
// handshake, exhaustion, reset and free-list wrap.
module tb_rename_stage;
    localparam int MO = 3;
    localparam int NP = 64;
    localparam int PW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_fu_choice;
    logic [5:0]    in_lrn_src [MO];
    logic [MO-1:0] in_src_mask;
    logic [5:0]    in_lrn_dst [MO];
    logic [MO-1:0] in_dst_mask;
    logic          out_valid;
    logic          out_ready;
    logic [2:0]    out_fu_choice;
    logic [PW-1:0] out_prn_src [MO];
    logic [PW-1:0] out_prn_dst [MO];
    logic [PW-1:0] out_prn_old [MO];
    logic [MO-1:0] out_dst_mask;
    logic [MO-1:0] free_valid;
    logic [PW-1:0] free_prn [MO];

    int vectors = 0;
    int miscompares = 0;

    logic [NP-1:0] free_set;
    logic [PW-1:0] rat_m [64];
    int            retire_q [$];
    logic          out_valid_m;

    always #5 clk = ~clk;

    rename_stage #(.MAX_OPERANDS(MO), .NUM_PRN(NP)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_fu_choice(in_fu_choice),
        .in_lrn_src(in_lrn_src), .in_src_mask(in_src_mask),
        .in_lrn_dst(in_lrn_dst), .in_dst_mask(in_dst_mask),
        .out_valid(out_valid), .out_ready(out_ready), .out_fu_choice(out_fu_choice),
        .out_prn_src(out_prn_src), .out_prn_dst(out_prn_dst), .out_prn_old(out_prn_old),
        .out_dst_mask(out_dst_mask),
        .free_valid(free_valid), .free_prn(free_prn)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        in_valid     = 1'b0;
        in_fu_choice = '0;
        in_src_mask  = '0;
        in_dst_mask  = '0;
        free_valid   = '0;
        for (int s = 0; s < MO; s++) begin
            in_lrn_src[s] = '0;
            in_lrn_dst[s] = '0;
            free_prn[s]   = '0;
        end
    endtask

    task automatic set_instr(input logic [2:0] fu, input logic [5:0] s0, s1, s2, input logic [2:0] sm,
                             input logic [5:0] d0, d1, d2, input logic [2:0] dm);
        in_valid      = 1'b1;
        in_fu_choice  = fu;
        in_lrn_src[0] = s0; in_lrn_src[1] = s1; in_lrn_src[2] = s2;
        in_lrn_dst[0] = d0; in_lrn_dst[1] = d1; in_lrn_dst[2] = d2;
        in_src_mask   = sm;
        in_dst_mask   = dm;
    endtask

    task automatic check_out(input string tag, input int s0, s1, s2, d0, d1, d2, o0, o1, o2, input int m);
        check({tag, " out_valid"}, out_valid, 1);
        check({tag, " src0"}, out_prn_src[0], s0);
        check({tag, " src1"}, out_prn_src[1], s1);
        check({tag, " src2"}, out_prn_src[2], s2);
        check({tag, " dst0"}, out_prn_dst[0], d0);
        check({tag, " dst1"}, out_prn_dst[1], d1);
        check({tag, " dst2"}, out_prn_dst[2], d2);
        check({tag, " old0"}, out_prn_old[0], o0);
        check({tag, " old1"}, out_prn_old[1], o1);
        check({tag, " old2"}, out_prn_old[2], o2);
        check({tag, " dst_mask"}, out_dst_mask, m);
    endtask

    function automatic logic [5:0] pick_lrn();
        int r;
        r = $urandom_range(0, 5);
        if (r == 5) return 6'd63;
        if (r == 4) return 6'd32;
        return 6'(r);
    endfunction

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        clear_in();
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", out_valid, 0);
        check("reset dst0", out_prn_dst[0], 0);
        check("reset fu", out_fu_choice, 0);
        rst_n = 1'b1;

        // x3 <- f(x5)
        set_instr(3'd5, 6'd5, 6'd0, 6'd0, 3'b001, 6'd3, 6'd0, 6'd0, 3'b001);
        #1 check("t1 in_ready", in_ready, 1);
        tick();
        check_out("t1", 6, 0, 0, 34, 0, 0, 4, 0, 0, 3'b001);
        check("t1 fu", out_fu_choice, 5);

        // flag <- f(x3): sees the previous instruction's mapping
        set_instr(3'd2, 6'd3, 6'd0, 6'd0, 3'b001, 6'd32, 6'd0, 6'd0, 3'b001);
        tick();
        check_out("t2", 34, 0, 0, 35, 0, 0, 33, 0, 0, 3'b001);

        // zero register on both sides, no allocation
        set_instr(3'd1, 6'd63, 6'd7, 6'd0, 3'b011, 6'd63, 6'd0, 6'd0, 3'b001);
        tick();
        check_out("t3", 0, 8, 0, 0, 0, 0, 0, 0, 0, 3'b000);

        // duplicate destinations x10,x10,x4; source x10 sees the old mapping
        set_instr(3'd3, 6'd10, 6'd0, 6'd0, 3'b001, 6'd10, 6'd10, 6'd4, 3'b111);
        tick();
        check_out("t4", 11, 0, 0, 36, 37, 38, 11, 11, 5, 3'b111);

        // highest duplicate wins in the RAT; masked src slot reads 0
        set_instr(3'd0, 6'd10, 6'd4, 6'd5, 3'b011, 6'd0, 6'd0, 6'd0, 3'b000);
        tick();
        check_out("t5", 37, 38, 0, 0, 0, 0, 0, 0, 0, 3'b000);

        // backpressure
        set_instr(3'd4, 6'd1, 6'd0, 6'd0, 3'b001, 6'd1, 6'd0, 6'd0, 3'b001);
        tick();
        check_out("bpA", 2, 0, 0, 39, 0, 0, 2, 0, 0, 3'b001);
        out_ready = 1'b0;
        set_instr(3'd6, 6'd1, 6'd0, 6'd0, 3'b001, 6'd2, 6'd0, 6'd0, 3'b001);
        for (int c = 0; c < 3; c++) begin
            #1 check("bp in_ready", in_ready, 0);
            tick();
            check_out("bp hold", 2, 0, 0, 39, 0, 0, 2, 0, 0, 3'b001);
            check("bp fu hold", out_fu_choice, 4);
        end
        out_ready = 1'b1;
        #1 check("bp resume in_ready", in_ready, 1);
        tick();
        check_out("bpB", 39, 0, 0, 40, 0, 0, 3, 0, 0, 3'b001);
        check("bpB fu", out_fu_choice, 6);
        clear_in();
        tick();
        check("drain out_valid", out_valid, 0);

        // exhaust the remaining 23 entries; head wraps past NUM_PRN
        for (int i = 0; i < 23; i++) begin
            set_instr(3'd0, 6'd0, 6'd0, 6'd0, 3'b000, 6'(i % 31), 6'd0, 6'd0, 3'b001);
            #1 check("exh in_ready", in_ready, 1);
            tick();
            check("exh dst0", out_prn_dst[0], 41 + i);
        end
        check("empty in_ready need1", in_ready, 0);
        clear_in();
        #1 check("empty in_ready need0", in_ready, 1);
        set_instr(3'd0, 6'd0, 6'd0, 6'd0, 3'b000, 6'd5, 6'd0, 6'd0, 3'b001);
        free_valid  = 3'b011;
        free_prn[0] = 6'd34;
        free_prn[1] = 6'd0;
        #1 check("release same-cycle in_ready", in_ready, 0);
        tick();
        free_valid = '0;
        check("idle out_valid", out_valid, 0);
        #1 check("released in_ready", in_ready, 1);
        tick();
        check("realloc dst0", out_prn_dst[0], 34);
        check("realloc out_valid", out_valid, 1);
        #1 check("prn0 ignored in_ready", in_ready, 0);

        // reset while an instruction is held
        out_ready = 1'b0;
        in_valid  = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid reset out_valid", out_valid, 0);
        check("mid reset dst0", out_prn_dst[0], 0);
        check("mid reset fu", out_fu_choice, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        clear_in();
        in_dst_mask = 3'b111;
        in_lrn_dst[0] = 6'd0; in_lrn_dst[1] = 6'd1; in_lrn_dst[2] = 6'd2;
        #1 check("post reset in_ready", in_ready, 1);

        // randomized phase against a behavioural free-set / RAT model
        free_set = '0;
        for (int p = 34; p < NP; p++) free_set[p] = 1'b1;
        for (int i = 0; i < 64; i++) rat_m[i] = (i <= 32) ? PW'(i + 1) : '0;
        out_valid_m = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            int   need_m;
            logic exp_ready;
            logic fire;
            logic later_dup;
            in_valid     = ($urandom_range(0, 9) < 8);
            out_ready    = ($urandom_range(0, 3) != 0);
            in_fu_choice = 3'($urandom_range(0, 7));
            in_src_mask  = 3'($urandom_range(0, 7));
            in_dst_mask  = 3'($urandom_range(0, 7));
            for (int s = 0; s < MO; s++) begin
                in_lrn_src[s] = pick_lrn();
                in_lrn_dst[s] = pick_lrn();
                free_valid[s] = 1'b0;
                free_prn[s]   = '0;
                if (retire_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                    free_valid[s] = 1'b1;
                    free_prn[s]   = PW'(retire_q.pop_front());
                end
            end
            #1;
            need_m = 0;
            for (int s = 0; s < MO; s++) if (in_dst_mask[s] && in_lrn_dst[s] != 6'd63) need_m++;
            exp_ready = (!out_valid_m || out_ready) && ($countones(free_set) >= need_m);
            check("rnd in_ready", in_ready, exp_ready);
            fire = in_valid && exp_ready;
            tick();
            if (fire) begin
                for (int s = 0; s < MO; s++) begin
                    logic alloc_s;
                    alloc_s = in_dst_mask[s] && in_lrn_dst[s] != 6'd63;
                    check("rnd src", out_prn_src[s],
                          (in_src_mask[s] && in_lrn_src[s] != 6'd63) ? rat_m[in_lrn_src[s]] : 0);
                    check("rnd dst_mask bit", out_dst_mask[s], alloc_s);
                    if (alloc_s) begin
                        check("rnd old", out_prn_old[s], rat_m[in_lrn_dst[s]]);
                        check("rnd dst was free", free_set[out_prn_dst[s]], 1);
                        free_set[out_prn_dst[s]] = 1'b0;
                    end else begin
                        check("rnd dst idle", out_prn_dst[s], 0);
                        check("rnd old idle", out_prn_old[s], 0);
                    end
                end
                for (int s = 0; s < MO; s++) begin
                    if (in_dst_mask[s] && in_lrn_dst[s] != 6'd63) begin
                        later_dup = 1'b0;
                        for (int t = s + 1; t < MO; t++)
                            if (in_dst_mask[t] && in_lrn_dst[t] == in_lrn_dst[s]) later_dup = 1'b1;
                        retire_q.push_back(later_dup ? int'(out_prn_dst[s]) : int'(out_prn_old[s]));
                    end
                end
                for (int s = 0; s < MO; s++)
                    if (in_dst_mask[s] && in_lrn_dst[s] != 6'd63) rat_m[in_lrn_dst[s]] = out_prn_dst[s];
            end
            for (int s = 0; s < MO; s++) if (free_valid[s]) free_set[free_prn[s]] = 1'b1;
            out_valid_m = fire ? 1'b1 : (out_ready ? 1'b0 : out_valid_m);
            check("rnd out_valid", out_valid, out_valid_m);
        end
        clear_in();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
